et_sng: RTL and testbench

- Early-terminating stochastic number generator: converts a W-bit unsigned binary value Bx into a unipolar stochastic bitstream whose probability is Bx/2^W.
- Stream length is cut to the minimum exact length 2^(W-tz), where tz is the number of trailing zeros of Bx.
- Transmit side of the zero-detection path: the detectors analyse a value's precision, and this block emits a stream at exactly that precision.

---
 rtl/et_sng_pkg.sv | 23 ++
 rtl/et_sng_if.sv | 29 ++
 rtl/et_sng_tz_count.sv | 22 ++
 rtl/et_sng.sv | 73 +++++++
 tb/tb_et_sng.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/et_sng_pkg.sv
// Purpose: shared types, widths and helpers for the early-terminating SNG.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package et_pkg;

  localparam int W  = 6;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    ET_IDLE = 1'b0,
    ET_RUN  = 1'b1
  } et_state_t;

  // W-bit mirror: bit i of the input lands on bit W-1-i of the result.
  function automatic logic [W-1:0] rev_bits(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[i] = v[W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/et_sng_if.sv
// Purpose: request + bitstream handshake bundle for et_sng.
// Latency: n/a (wiring only).
// Backpressure: bit_valid/bit_ready on the stream side, start/ready on the load side.
// Ports: start/ready/Bx load a value; bit_out/bit_valid/bit_ready/last/len_log2 carry the stream.
interface et_sng_if;
  import et_pkg::*;

  logic          start;
  logic          ready;
  logic [W-1:0]  Bx;
  logic          bit_out;
  logic          bit_valid;
  logic          bit_ready;
  logic          last;
  logic [CW-1:0] len_log2;

  // master: the producer of requests and consumer of the stream
  modport master (
    output start, Bx, bit_ready,
    input  ready, bit_out, bit_valid, last, len_log2
  );

  // slave: the generator itself
  modport slave (
    input  start, Bx, bit_ready,
    output ready, bit_out, bit_valid, last, len_log2
  );

endinterface

// File: rtl/et_sng_tz_count.sv
// Purpose: trailing-zero count of a W-bit value; all-zero input yields W.
// Latency: combinational.
// Backpressure: none.
// Ports: v_i value in, tz_o count out (CW bits).
module tz_count
  import et_pkg::*;
(
  input  logic [W-1:0]  v_i,
  output logic [CW-1:0] tz_o
);

  // Scan from MSB down so the lowest set bit is the last one to write.
  always_comb begin
    tz_o = CW'(W);
    for (int i = W - 1; i >= 0; i--) begin
      if (v_i[i]) begin
        tz_o = CW'(i);
      end
    end
  end

endmodule

// File: rtl/et_sng.sv
// Purpose: convert Bx into a unipolar bitstream of exact length 2^(W-tz(Bx)).
// Latency: first bit valid the cycle after start is accepted; one idle bubble between streams.
// Backpressure: bit_ready=0 holds bit_out/last/cnt; start is only taken while ready.
// Ports: clk, rst_n (async active-low), bus (et_sng_if.slave).
module et_sng
  import et_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  et_sng_if.slave bus
);

  et_state_t     state_q;
  logic [W-1:0]  cnt_q;
  logic [W-1:0]  cnt_d;
  logic [W-1:0]  bx_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] tz;
  logic [W:0]    len_span;
  logic          run;
  logic          last_w;

  tz_count u_tz (
    .v_i  (bus.Bx),
    .tz_o (tz)
  );

  assign run   = (state_q == ET_RUN);
  assign cnt_d = cnt_q + W'(1);

  // W+1 bits so len_q == W (span 2^W) does not overflow.
  assign len_span = (W+1)'(1) << len_q;
  assign last_w   = run && ({1'b0, cnt_q} == (len_span - (W+1)'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ET_IDLE;
      cnt_q   <= '0;
      bx_q    <= '0;
      len_q   <= '0;
    end else begin
      case (state_q)
        ET_IDLE: begin
          if (bus.start) begin
            bx_q    <= bus.Bx;
            len_q   <= CW'(W) - tz;
            cnt_q   <= '0;
            state_q <= ET_RUN;
          end
        end
        ET_RUN: begin
          if (bus.bit_ready) begin
            if (last_w) begin
              cnt_q   <= '0;
              state_q <= ET_IDLE;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        default: state_q <= ET_IDLE;
      endcase
    end
  end

  // Outputs decode only from registered state, so start/Bx never reach them combinationally.
  assign bus.ready     = !run;
  assign bus.bit_valid = run;
  assign bus.bit_out   = run && (bx_q > rev_bits(cnt_q));
  assign bus.last      = last_w;
  assign bus.len_log2  = len_q;

endmodule

// File: tb/tb_et_sng.sv
module tb_et_sng;
  import et_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  et_sng_if ifc();

  et_sng dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  // standalone trailing-zero counter for the mask cross-check
  logic [W-1:0]  tz_in;
  logic [CW-1:0] tz_out;
  tz_count u_tzc (.v_i(tz_in), .tz_o(tz_out));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic exp_q[$];
  int   m_run = 0;
  int   m_idx = 0;
  int   m_len = 0;
  int   done_cnt = 0;
  logic cap_q[$];
  logic cap_last[$];

  function automatic int m_rev(input int k);
    int r = 0;
    int x = k;
    for (int b = 0; b < W; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic int m_tz(input int v);
    int t = 0;
    int x = v;
    while (t < W && (x % 2) == 0) begin
      t++;
      x = x / 2;
    end
    return t;
  endfunction

  task automatic m_load(input int bx);
    int n;
    m_len = W - m_tz(bx);
    n = 1 << m_len;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(bx > m_rev(k));
    m_idx = 0;
    m_run = 1;
  endtask

  // one compare process: check outputs mid-cycle, then advance the model
  always @(negedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_idx = 0; m_len = 0;
      chk("rst_ready", int'(ifc.ready), 1);
      chk("rst_valid", int'(ifc.bit_valid), 0);
      chk("rst_bit", int'(ifc.bit_out), 0);
      chk("rst_last", int'(ifc.last), 0);
      chk("rst_len", int'(ifc.len_log2), 0);
    end else begin
      chk("ready", int'(ifc.ready), m_run ? 0 : 1);
      chk("valid", int'(ifc.bit_valid), m_run);
      chk("bit_out", int'(ifc.bit_out), m_run ? int'(exp_q[m_idx]) : 0);
      chk("last", int'(ifc.last), m_run ? int'(m_idx == exp_q.size() - 1) : 0);
      chk("len_log2", int'(ifc.len_log2), m_len);
      if (m_run != 0) begin
        if (ifc.bit_ready) begin
          cap_q.push_back(ifc.bit_out);
          cap_last.push_back(ifc.last);
          if (m_idx == exp_q.size() - 1) begin
            m_run = 0;
            done_cnt++;
          end else begin
            m_idx++;
          end
        end
      end else if (ifc.start) begin
        m_load(int'(ifc.Bx));
      end
    end
  end

  // ---------------- stimulus ----------------
  // mode 0: bit_ready always 1; 1: pattern 1,0,0 repeating; 2: random
  task automatic run_stream(input logic [W-1:0] bx, input int mode, input bit noise);
    int d0;
    int cyc;
    d0 = done_cnt;
    cyc = 0;
    cap_q.delete();
    cap_last.delete();
    @(posedge clk); #1;
    ifc.start = 1'b1;
    ifc.Bx = bx;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    while (done_cnt == d0 && cyc < 5000) begin
      case (mode)
        0: ifc.bit_ready = 1'b1;
        1: ifc.bit_ready = ((cyc % 3) == 0);
        default: ifc.bit_ready = 1'($urandom_range(0, 1));
      endcase
      if (noise) begin
        ifc.start = 1'($urandom_range(0, 1));
        ifc.Bx = W'($urandom);
      end
      @(posedge clk); #1;
      ifc.start = 1'b0;
      cyc++;
    end
    if (cyc >= 5000) chk("stream_timeout", 1, 0);
    @(negedge clk);
    chk("ready_after", int'(ifc.ready), 1);
  endtask

  function automatic int ones_of_cap();
    int s = 0;
    foreach (cap_q[i]) s += int'(cap_q[i]);
    return s;
  endfunction

  function automatic int lasts_before_end();
    int s = 0;
    for (int i = 0; i + 1 < cap_last.size(); i++) s += int'(cap_last[i]);
    return s;
  endfunction

  task automatic chk_1110(input string tag);
    chk({tag, "_beats"}, cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk({tag, "_b0"}, int'(cap_q[0]), 1);
      chk({tag, "_b1"}, int'(cap_q[1]), 1);
      chk({tag, "_b2"}, int'(cap_q[2]), 1);
      chk({tag, "_b3"}, int'(cap_q[3]), 0);
      chk({tag, "_last"}, int'(cap_last[3]), 1);
    end
  endtask

  initial begin
    int cyc;
    logic [W:0] mask;
    logic [W:0] onehot;
    ifc.start = 1'b0;
    ifc.Bx = '0;
    ifc.bit_ready = 1'b0;
    tz_in = '0;

    // tz_count one-hot vs lowest-set-bit mask, every value
    for (int v = 0; v < (1 << W); v++) begin
      tz_in = W'(v);
      #1;
      mask = (v == 0) ? (W+1)'(1) << W : (W+1)'(v & -v);
      onehot = (W+1)'(1) << tz_out;
      chk("tz_onehot_vs_mask", int'(onehot), int'(mask));
    end

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // model pins
    chk("model_rev1", m_rev(1), 32);
    chk("model_rev3", m_rev(3), 48);
    chk("model_tz0", m_tz(0), W);

    run_stream(6'b001100, 0, 0);
    chk("s12_beats", cap_q.size(), 16);
    chk("s12_ones", ones_of_cap(), 3);
    chk("s12_first", int'(cap_q[0]), 1);
    chk("s12_early_last", lasts_before_end(), 0);
    chk("s12_len", int'(ifc.len_log2), 4);

    run_stream(6'b110000, 0, 0);
    chk_1110("s48");
    chk("s48_len", int'(ifc.len_log2), 2);

    run_stream(6'b111111, 0, 0);
    chk("s63_beats", cap_q.size(), 64);
    chk("s63_ones", ones_of_cap(), 63);
    chk("s63_final", int'(cap_q[cap_q.size()-1]), 0);
    chk("s63_early_last", lasts_before_end(), 0);

    run_stream(6'b000000, 0, 0);
    chk("s0_beats", cap_q.size(), 1);
    chk("s0_bit", int'(cap_q[0]), 0);
    chk("s0_last", int'(cap_last[0]), 1);
    chk("s0_len", int'(ifc.len_log2), 0);

    run_stream(6'b000011, 1, 1);
    chk("s3_beats", cap_q.size(), 64);
    chk("s3_ones", ones_of_cap(), 3);

    for (int t = 0; t < 12; t++) begin
      logic [W-1:0] bx;
      bx = W'($urandom);
      run_stream(bx, 2, 1);
      chk("rnd_ones", ones_of_cap(), int'(bx) >> m_tz(int'(bx)));
      chk("rnd_beats", cap_q.size(), 1 << (W - m_tz(int'(bx))));
    end

    // abort mid-stream with reset, then a clean stream
    cap_q.delete();
    cap_last.delete();
    @(posedge clk); #1;
    ifc.start = 1'b1;
    ifc.Bx = 6'b001100;
    ifc.bit_ready = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    cyc = 0;
    while (cap_q.size() < 5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) chk("abort_timeout", 1, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", int'(ifc.ready), 1);
    chk("abort_valid", int'(ifc.bit_valid), 0);
    chk("abort_bit", int'(ifc.bit_out), 0);
    chk("abort_len", int'(ifc.len_log2), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_stream(6'b110000, 0, 0);
    chk_1110("post_rst");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
